// File: rtl/result_memory_reader_pkg.sv
// Shared definitions for the result memory reader and the processing FSM that packs sample words.
// Field positions here are the single source of truth for the 32-bit sample layout.
package result_memory_reader_pkg;

    localparam int MEM_ADDR_W    = 15;
    localparam int SAMPLE_WORD_W = 32;
    localparam int COUNT_W       = 16;

    localparam int SAMPLE_INPUT_MSB    = 31;
    localparam int SAMPLE_INPUT_LSB    = 24;
    localparam int SAMPLE_SEQ_MSB      = 23;
    localparam int SAMPLE_SEQ_LSB      = 16;
    localparam int SAMPLE_EXPECTED_MSB = 15;
    localparam int SAMPLE_EXPECTED_LSB = 8;
    localparam int SAMPLE_CHROM_MSB    = 7;
    localparam int SAMPLE_CHROM_LSB    = 0;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_SEND  = 3'd3,
        RD_DONE  = 3'd4
    } reader_state_e;

    function automatic logic sample_mismatch(input logic [SAMPLE_WORD_W-1:0] word);
        return word[SAMPLE_CHROM_MSB:SAMPLE_CHROM_LSB]
            != word[SAMPLE_EXPECTED_MSB:SAMPLE_EXPECTED_LSB];
    endfunction

endpackage

// File: rtl/result_memory_reader_serializer.sv
// Loads a 32-bit word and presents it as 4 bytes MSB first; byte 0 is valid the cycle after load.
// Backpressure: a byte holds stable until byte_rdy; last_acc pulses when the 4th byte is taken.
module word_byte_serializer
    import result_memory_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_vld,
    input  logic [SAMPLE_WORD_W-1:0] word_dat,
    input  logic                     byte_rdy,
    output logic [7:0]               byte_dat,
    output logic                     byte_vld,
    output logic                     last_acc
);

    logic [SAMPLE_WORD_W-1:0] shift_q;
    logic [1:0]               idx_q;
    logic                     vld_q;
    logic                     acc;

    assign acc      = vld_q & byte_rdy;
    assign byte_dat = shift_q[SAMPLE_WORD_W-1 -: 8];
    assign byte_vld = vld_q;
    assign last_acc = acc & (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
        end else if (load_vld) begin
            shift_q <= word_dat;
            idx_q   <= 2'd0;
            vld_q   <= 1'b1;
        end else if (acc) begin
            shift_q <= {shift_q[SAMPLE_WORD_W-9:0], 8'h00};
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/result_memory_reader.sv
// Streams result-RAM sample words out MSB byte first and counts chromOut/expected mismatches.
// Per word: 1 issue + READ_LATENCY wait + 4 send cycles; the byte stream stalls freely on iByteReady.
module result_memory_reader
    import result_memory_reader_pkg::*;
#(
    parameter int READ_LATENCY   = 2,
    parameter int MEM_DEPTH_LOG2 = MEM_ADDR_W
)
(
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic                      iStartReading,
    input  logic [MEM_DEPTH_LOG2-1:0] iBaseAddr,
    input  logic [COUNT_W-1:0]        iWordCount,
    output logic                      oReadyToRead,
    output logic                      oDoneReading,
    input  logic                      iDoneReadingFeedback,
    output logic [MEM_DEPTH_LOG2-1:0] oMemAddr,
    output logic                      oMemReadEnable,
    input  logic [SAMPLE_WORD_W-1:0]  iMemData,
    output logic [7:0]                oByte,
    output logic                      oByteValid,
    input  logic                      iByteReady,
    output logic [COUNT_W-1:0]        oMismatchCount,
    output logic [2:0]                oState
);

    localparam logic [2:0] IDLE  = RD_IDLE;
    localparam logic [2:0] ISSUE = RD_ISSUE;
    localparam logic [2:0] WAIT  = RD_WAIT;
    localparam logic [2:0] SEND  = RD_SEND;
    localparam logic [2:0] DONE  = RD_DONE;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    logic [2:0]                state_q;
    logic [MEM_DEPTH_LOG2-1:0] addr_q;
    logic [COUNT_W-1:0]        remaining_q;
    logic [1:0]                wait_cnt_q;
    logic [COUNT_W-1:0]        mismatch_q;
    logic                      capture;
    logic                      last_acc;

    assign capture        = (state_q == WAIT) && (wait_cnt_q == WAIT_LAST);
    assign oReadyToRead   = (state_q == IDLE);
    assign oDoneReading   = (state_q == DONE);
    assign oMemReadEnable = (state_q == ISSUE);
    assign oMemAddr       = addr_q;
    assign oMismatchCount = mismatch_q;
    assign oState         = state_q;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= 2'd0;
            mismatch_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iStartReading) begin
                        addr_q      <= iBaseAddr;
                        remaining_q <= iWordCount;
                        mismatch_q  <= '0;
                        state_q     <= (iWordCount == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= 2'd0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        // Saturate rather than wrap so a huge dump never reports a small count.
                        if (sample_mismatch(iMemData) && (mismatch_q != {COUNT_W{1'b1}})) begin
                            mismatch_q <= mismatch_q + COUNT_W'(1);
                        end
                        state_q <= SEND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                SEND: begin
                    if (last_acc) begin
                        remaining_q <= remaining_q - COUNT_W'(1);
                        if (remaining_q == COUNT_W'(1)) begin
                            state_q <= DONE;
                        end else begin
                            addr_q  <= addr_q + MEM_DEPTH_LOG2'(1);
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (iDoneReadingFeedback) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    word_byte_serializer u_serializer (
        .clk      (iClock),
        .rst      (iReset),
        .load_vld (capture),
        .word_dat (iMemData),
        .byte_rdy (iByteReady),
        .byte_dat (oByte),
        .byte_vld (oByteValid),
        .last_acc (last_acc)
    );

endmodule
